// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding, access-size codes and the timeout
// counter width helper for the MEM-stage load/store unit.
package mem_stage_pkg;

   // Two-state access FSM, kept as plain constants so older tools can read it.
   typedef logic [0:0] lsu_state_t;
   localparam lsu_state_t IDLE   = 1'b0;
   localparam lsu_state_t ACCESS = 1'b1;

   // Access size codes used when sub-word accesses are enabled.
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Bits needed to count 0..timeout-1 ACCESS cycles.
   function automatic int timeout_cnt_w(input int timeout);
      return (timeout <= 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: sub-word helper for the load/store unit. Builds byte enables,
// checks alignment by access size, replicates store data into every lane and
// extracts/extends the addressed lane of load data. Assumes 32-bit data.
module lsu_align
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        req_size,
   input  logic [1:0]        req_addr_lo,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              aligned,
   output logic [3:0]        be,
   output logic [DATA_W-1:0] wdata_lanes,
   input  logic [1:0]        ld_size,
   input  logic              ld_sign,
   input  logic [1:0]        ld_addr_lo,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] rdata_ext
);

   logic [DATA_W-1:0] shifted;

   assign shifted = rdata >> {ld_addr_lo, 3'b000};

   // Request side: alignment, byte enables and lane-replicated store data.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      aligned     = 1'b1;
      be          = 4'hF;
      wdata_lanes = req_wdata;
      case (req_size)
         SIZE_BYTE: begin
            be          = 4'b0001 << req_addr_lo;
            wdata_lanes = {(DATA_W/8){req_wdata[7:0]}};
         end
         SIZE_HALF: begin
            aligned     = ~req_addr_lo[0];
            be          = req_addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {(DATA_W/16){req_wdata[15:0]}};
         end
         default: aligned = (req_addr_lo == 2'b00);
      endcase
   end

   // Load side: pick the addressed lane and sign- or zero-extend it.
   always_comb begin
      rdata_ext = rdata;
      case (ld_size)
         SIZE_BYTE: rdata_ext = {{(DATA_W-8){ld_sign & shifted[7]}}, shifted[7:0]};
         SIZE_HALF: rdata_ext = {{(DATA_W-16){ld_sign & shifted[15]}}, shifted[15:0]};
         default:   rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage of the pipelined datapath. Runs loads/stores over a
// req/ack data-memory port, resolves the branch (PCSrc), stalls upstream while
// an access is outstanding and owns the MEM/WB register.
// Optional feature: define LSU_SUBWORD_EN for byte/half accesses (mem_size,
// mem_sign, mem_be); without it every access is a full aligned word.
module mem_stage_lsu
   import mem_stage_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  RegWrite,
   input  logic                  MemToReg,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic                  Branch,
   input  logic                  Zero,
   input  logic [DATA_W-1:0]     ALUResult,
   input  logic [DATA_W-1:0]     WriteMemData,
   input  logic [REG_ADDR_W-1:0] WriteReg,
`ifdef LSU_SUBWORD_EN
   input  logic [1:0]            mem_size,
   input  logic                  mem_sign,
   output logic [3:0]            mem_be,
`endif
   output logic                  PCSrc,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  mem_err,
   output logic                  wb_valid,
   output logic                  wb_RegWrite,
   output logic                  wb_MemToReg,
   output logic [DATA_W-1:0]     wb_ReadData,
   output logic [DATA_W-1:0]     wb_ALUResult,
   output logic [REG_ADDR_W-1:0] wb_WriteReg
);

   localparam int               CNT_W    = timeout_cnt_w(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_t            state;
   logic [CNT_W-1:0]      cnt;
   logic                  lat_reg_write;
   logic                  lat_mem_to_reg;
   logic                  lat_store;
   logic [DATA_W-1:0]     lat_alu_result;
   logic [REG_ADDR_W-1:0] lat_write_reg;

   logic                  mem_op;
   logic                  aligned;
   logic                  in_access;
   logic                  start;
   logic                  misaligned;
   logic                  timeout_hit;
   logic [DATA_W-1:0]     store_data;
   logic [DATA_W-1:0]     load_data;

`ifdef LSU_SUBWORD_EN
   logic [1:0] lat_size;
   logic [1:0] lat_addr_lo;
   logic       lat_sign;
   logic [3:0] be_next;

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .req_size    (mem_size),
      .req_addr_lo (ALUResult[1:0]),
      .req_wdata   (WriteMemData),
      .aligned     (aligned),
      .be          (be_next),
      .wdata_lanes (store_data),
      .ld_size     (lat_size),
      .ld_sign     (lat_sign),
      .ld_addr_lo  (lat_addr_lo),
      .rdata       (mem_rdata),
      .rdata_ext   (load_data)
   );
`else
   assign aligned    = (ALUResult[1:0] == 2'b00);
   assign store_data = WriteMemData;
   assign load_data  = mem_rdata;
`endif

   assign mem_op      = in_valid & (MemRead | MemWrite);
   assign in_access   = (state == ACCESS);
   assign start       = ~in_access & mem_op & aligned;
   assign misaligned  = ~in_access & mem_op & ~aligned;
   // An ack arriving on the last allowed cycle takes priority over the timeout.
   assign timeout_hit = in_access & ~mem_ack & (cnt == CNT_LAST);
   assign stall       = start | (in_access & ~mem_ack);
   assign PCSrc       = Branch & Zero & in_valid;

   // Access FSM, memory port registers and the MEM/WB pipeline register.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the latched-op registers are reset too, so a reset in ACCESS
         // leaves no stale operation behind.
         state          <= IDLE;
         cnt            <= '0;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         mem_err        <= 1'b0;
         wb_valid       <= 1'b0;
         wb_RegWrite    <= 1'b0;
         wb_MemToReg    <= 1'b0;
         wb_ReadData    <= '0;
         wb_ALUResult   <= '0;
         wb_WriteReg    <= '0;
         lat_reg_write  <= 1'b0;
         lat_mem_to_reg <= 1'b0;
         lat_store      <= 1'b0;
         lat_alu_result <= '0;
         lat_write_reg  <= '0;
`ifdef LSU_SUBWORD_EN
         mem_be         <= '0;
         lat_size       <= '0;
         lat_addr_lo    <= '0;
         lat_sign       <= 1'b0;
`endif
      end else if (!in_access) begin
         if (start) begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state          <= ACCESS;
            cnt            <= '0;
            mem_req        <= 1'b1;
            mem_we         <= MemWrite;
            mem_addr       <= {ALUResult[DATA_W-1:2], 2'b00};
            mem_wdata      <= store_data;
            wb_valid       <= 1'b0;
            lat_reg_write  <= RegWrite;
            lat_mem_to_reg <= MemToReg;
            lat_store      <= MemWrite;
            lat_alu_result <= ALUResult;
            lat_write_reg  <= WriteReg;
`ifdef LSU_SUBWORD_EN
            mem_be         <= be_next;
            lat_size       <= mem_size;
            lat_addr_lo    <= ALUResult[1:0];
            lat_sign       <= mem_sign;
`endif
         end else if (misaligned) begin
            mem_err     <= 1'b1;
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
         end else begin
            wb_valid     <= in_valid;
            wb_RegWrite  <= RegWrite;
            wb_MemToReg  <= MemToReg;
            wb_ReadData  <= '0;
            wb_ALUResult <= ALUResult;
            wb_WriteReg  <= WriteReg;
         end
      end else begin
         cnt <= cnt + 1'b1;
         if (mem_ack || timeout_hit) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            wb_valid     <= 1'b1;
            wb_MemToReg  <= lat_mem_to_reg;
            wb_ALUResult <= lat_alu_result;
            wb_WriteReg  <= lat_write_reg;
            if (mem_ack) begin
               wb_RegWrite <= lat_reg_write;
               wb_ReadData <= lat_store ? '0 : load_data;
            end else begin
               mem_err     <= 1'b1;
               wb_RegWrite <= 1'b0;
               wb_ReadData <= '0;
            end
         end else begin
            wb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed bench for mem_stage_lsu (word mode). A
// transaction-level model tracks the outstanding access as "cycles waited"
// and predicts every output; literal checks pin the model to known values.
`timescale 1ns/1ps
module tb_mem_stage_lsu;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int TIMEOUT    = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid, RegWrite, MemToReg, MemRead, MemWrite, Branch, Zero;
   logic [DATA_W-1:0]     ALUResult, WriteMemData;
   logic [REG_ADDR_W-1:0] WriteReg;
   logic                  PCSrc, stall, mem_req, mem_we, mem_ack, mem_err;
   logic [DATA_W-1:0]     mem_addr, mem_wdata, mem_rdata;
   logic                  wb_valid, wb_RegWrite, wb_MemToReg;
   logic [DATA_W-1:0]     wb_ReadData, wb_ALUResult;
   logic [REG_ADDR_W-1:0] wb_WriteReg;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .RegWrite(RegWrite), .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite),
      .Branch(Branch), .Zero(Zero), .ALUResult(ALUResult), .WriteMemData(WriteMemData),
      .WriteReg(WriteReg), .PCSrc(PCSrc), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .mem_err(mem_err), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
      .wb_MemToReg(wb_MemToReg), .wb_ReadData(wb_ReadData), .wb_ALUResult(wb_ALUResult),
      .wb_WriteReg(wb_WriteReg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   bit          live = 0;
   bit          busy = 0;
   int          waited;
   bit          op_rw, op_m2r, op_store;
   logic [31:0] op_alu;
   logic [4:0]  op_wr;
   bit          e_req, e_we, e_err, e_wbv, e_rw, e_m2r;
   logic [31:0] e_addr, e_wdata, e_rd, e_alu;
   logic [4:0]  e_wr;

   initial begin
      bit memop, algn;
      forever begin
         @(negedge clk);
         memop = in_valid && (MemRead || MemWrite);
         algn  = (ALUResult[1:0] == 2'b00);
         if (live) begin
            check("stall", stall, (!busy && memop && algn) || (busy && !mem_ack));
            check("pcsrc", PCSrc, Branch && Zero && in_valid);
            check("mem_req", mem_req, e_req);
            check("mem_err", mem_err, e_err);
            check("wb_valid", wb_valid, e_wbv);
            if (e_req) begin
               check("mem_we", mem_we, e_we);
               check("mem_addr", mem_addr, e_addr);
               check("mem_wdata", mem_wdata, e_wdata);
            end
            if (e_wbv) begin
               check("wb_RegWrite", wb_RegWrite, e_rw);
               check("wb_MemToReg", wb_MemToReg, e_m2r);
               check("wb_ReadData", wb_ReadData, e_rd);
               check("wb_ALUResult", wb_ALUResult, e_alu);
               check("wb_WriteReg", wb_WriteReg, e_wr);
            end
         end
         // Predict what the outputs will be after the coming edge.
         if (rst) begin
            live = 1; busy = 0;
            e_req = 0; e_we = 0; e_err = 0; e_wbv = 0; e_rw = 0; e_m2r = 0;
            e_addr = 0; e_wdata = 0; e_rd = 0; e_alu = 0; e_wr = 0;
         end else if (!busy) begin
            if (memop && algn) begin
               busy = 1; waited = 0;
               op_rw = RegWrite; op_m2r = MemToReg; op_store = MemWrite;
               op_alu = ALUResult; op_wr = WriteReg;
               e_req = 1; e_we = MemWrite; e_addr = ALUResult; e_wdata = WriteMemData;
               e_wbv = 0;
            end else if (memop) begin
               e_err = 1; e_wbv = 0;
            end else begin
               e_wbv = in_valid; e_rw = RegWrite; e_m2r = MemToReg;
               e_rd = 0; e_alu = ALUResult; e_wr = WriteReg;
            end
         end else begin
            waited++;
            if (mem_ack || waited == TIMEOUT) begin
               busy = 0; e_req = 0; e_wbv = 1;
               e_m2r = op_m2r; e_alu = op_alu; e_wr = op_wr;
               if (mem_ack) begin
                  e_rw = op_rw; e_rd = op_store ? 32'h0 : mem_rdata;
               end else begin
                  e_err = 1; e_rw = 0; e_rd = 0;
               end
            end else begin
               e_wbv = 0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic v, rw, m2r, mr, mw,
                         input logic [31:0] alu, wd, input logic [4:0] wr);
      in_valid = v; RegWrite = rw; MemToReg = m2r; MemRead = mr; MemWrite = mw;
      ALUResult = alu; WriteMemData = wd; WriteReg = wr; Branch = 0; Zero = 0;
   endtask

   task automatic bubble();
      set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
   endtask

   // Memory responder: acks on request cycle ack_after+1 (never if negative).
   task automatic run_access(input int ack_after, input logic [31:0] rdata,
                             output int stalls, output int reqs);
      stalls = 0;
      reqs   = 0;
      for (int i = 0; i < 64; i++) begin
         if (reqs > 0 && !mem_req) return;
         if (mem_req) reqs++;
         if (ack_after >= 0 && reqs == ack_after + 1) begin
            mem_ack = 1; mem_rdata = rdata;
         end
         #1;
         if (stall) stalls++;
         @(posedge clk);
         #1;
         if (mem_ack) begin
            mem_ack = 0; mem_rdata = '0;
            return;
         end
      end
      n_tests++;
      n_fail++;
      $display("FAIL access_bound: access still open after 64 cycles");
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_req"}, mem_req, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_mem_err"}, mem_err, 0);
      check({tag, "_wb_valid"}, wb_valid, 0);
      check({tag, "_wb_RegWrite"}, wb_RegWrite, 0);
      check({tag, "_wb_MemToReg"}, wb_MemToReg, 0);
      check({tag, "_wb_ReadData"}, wb_ReadData, 0);
      check({tag, "_wb_ALUResult"}, wb_ALUResult, 0);
      check({tag, "_wb_WriteReg"}, wb_WriteReg, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int stalls, reqs;
      rst = 1; bubble(); mem_ack = 0; mem_rdata = '0;
      repeat (2) step();
      check_all_zero("reset");
      rst = 0;

      // ALU op, latency 1
      set_op(1, 1, 0, 0, 0, 32'h2A, 32'h0, 5'd5);
      #1 check("alu_stall", stall, 0);
      step();
      check("alu_wb_valid", wb_valid, 1);
      check("alu_wb_ALUResult", wb_ALUResult, 32'h2A);
      check("alu_wb_WriteReg", wb_WriteReg, 5);
      check("alu_wb_RegWrite", wb_RegWrite, 1);

      // Load 0x100, ack on the 4th request cycle
      set_op(1, 1, 1, 1, 0, 32'h100, 32'h0, 5'd7);
      run_access(3, 32'h12345678, stalls, reqs);
      bubble();
      check("load_stall_cycles", stalls, 4);
      check("load_req_cycles", reqs, 4);
      check("load_wb_valid", wb_valid, 1);
      check("load_wb_ReadData", wb_ReadData, 32'h12345678);
      check("load_wb_WriteReg", wb_WriteReg, 7);

      // Store 0x104
      set_op(1, 0, 0, 0, 1, 32'h104, 32'hCAFEF00D, 5'd0);
      step();
      check("store_mem_req", mem_req, 1);
      check("store_mem_we", mem_we, 1);
      check("store_mem_addr", mem_addr, 32'h104);
      check("store_mem_wdata", mem_wdata, 32'hCAFEF00D);
      run_access(1, 32'hDEADBEEF, stalls, reqs);
      bubble();
      check("store_req_cycles", reqs, 2);
      check("store_wb_valid", wb_valid, 1);
      check("store_wb_RegWrite", wb_RegWrite, 0);
      check("store_wb_ReadData", wb_ReadData, 0);

      // MemRead and MemWrite both set behaves as a store
      set_op(1, 1, 0, 1, 1, 32'h200, 32'h55AA55AA, 5'd3);
      step();
      check("rw_mem_we", mem_we, 1);
      run_access(0, 32'h11111111, stalls, reqs);
      bubble();
      check("rw_wb_ReadData", wb_ReadData, 0);

      // Ack on the timeout cycle: ack wins
      set_op(1, 1, 1, 1, 0, 32'h300, 32'h0, 5'd9);
      run_access(15, 32'hA5A5A5A5, stalls, reqs);
      bubble();
      check("acklast_req_cycles", reqs, 16);
      check("acklast_mem_err", mem_err, 0);
      check("acklast_wb_ReadData", wb_ReadData, 32'hA5A5A5A5);
      check("acklast_wb_RegWrite", wb_RegWrite, 1);

      // Stray ack in IDLE is ignored
      mem_ack = 1; mem_rdata = 32'hFFFF0000;
      #1 check("idleack_stall", stall, 0);
      step();
      mem_ack = 0; mem_rdata = '0;
      check("idleack_mem_req", mem_req, 0);
      check("idleack_wb_valid", wb_valid, 0);

      // Branch resolution
      set_op(1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      Branch = 1; Zero = 1;
      #1 check("branch_taken", PCSrc, 1);
      Zero = 0;
      #1 check("branch_not_taken", PCSrc, 0);
      step();
      bubble();

      // Misaligned word load
      set_op(1, 1, 1, 1, 0, 32'h102, 32'h0, 5'd4);
      #1 check("misalign_stall", stall, 0);
      step();
      bubble();
      check("misalign_mem_req", mem_req, 0);
      check("misalign_mem_err", mem_err, 1);
      check("misalign_wb_valid", wb_valid, 0);

      // Timeout: no ack at all
      set_op(1, 1, 1, 1, 0, 32'h400, 32'h0, 5'd6);
      run_access(-1, 32'h0, stalls, reqs);
      bubble();
      check("timeout_req_cycles", reqs, 16);
      check("timeout_mem_err", mem_err, 1);
      check("timeout_wb_valid", wb_valid, 1);
      check("timeout_wb_RegWrite", wb_RegWrite, 0);
      repeat (3) step();
      check("timeout_err_sticky", mem_err, 1);

      // Reset in the middle of an access
      set_op(1, 1, 1, 1, 0, 32'h500, 32'h0, 5'd8);
      repeat (2) step();
      check("rstmid_mem_req", mem_req, 1);
      rst = 1; Branch = 1; Zero = 1;
      #1 check("rstmid_pcsrc", PCSrc, 1);
      step();
      check_all_zero("rstmid");
      rst = 0;
      bubble();
      repeat (2) step();
      check("post_rst_wb_valid", wb_valid, 0);
      check("post_rst_mem_req", mem_req, 0);

      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
